// File: rtl/cpu_hazard_pkg.sv
// cpu_hazard_pkg: shared constants for the pipeline hazard controller.
// Holds the FSM state encodings, state/register widths and the load-use test.
package cpu_hazard_pkg;

    localparam int STATE_W = 2;
    localparam int REG_W   = 5;

    localparam logic [STATE_W-1:0] RUN   = 2'd0;
    localparam logic [STATE_W-1:0] WAIT  = 2'd1;
    localparam logic [STATE_W-1:0] ABORT = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN   = RUN,
        ST_WAIT  = WAIT,
        ST_ABORT = ABORT
    } state_e;

    // True when the EX load writes a register the ID instruction reads.
    function automatic logic load_use(
        input logic             mem_read,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input logic             use1,
        input logic             use2
    );
        return mem_read && (rd != '0) &&
               ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping stall-cycle and flush counters (HAZARD_PERF_CNT_EN).
// Ports: clk, rst, stall_i, flush_i in; stall_cycles_o, flush_cnt_o out.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q + {{(CNT_W-1){1'b0}}, stall_i};
        flush_d = flush_q + {{(CNT_W-1){1'b0}}, flush_i};
    end

    // Reset clears both counts, so reset-cycle flushes are never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_cnt_o    = flush_q;

endmodule
`else
`endif

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall, branch squash and data-memory freeze control.
// Ports: ID/EX register fields, EX load/branch, MEM req/ack in; stall_if,
// bubble_ex, flush_id, freeze, mem_err, state_dbg out. HAZARD_PERF_CNT_EN adds
// stall_cycles_o and flush_cnt_o.
module hazard_stall_unit
    import cpu_hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ack_mem,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             freeze,
    output logic             mem_err,
    output logic [1:0]       state_dbg
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic            frz;
    logic            lu;

    assign lu = load_use(mem_read_ex, rd_ex, rs1_id, rs2_id,
                         uses_rs1_id, uses_rs2_id);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        frz        = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (dmem_req_mem && !dmem_ack_mem) begin
                    frz        = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (dmem_ack_mem) begin
                    state_d = ST_RUN;
                end else begin
                    frz = 1'b1;
                    if (wait_cnt_q != WC_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    // This cycle's increment brings the count to the limit.
                    if (wait_cnt_q == WC_LAST) begin
                        state_d   = ST_ABORT;
                        mem_err_d = 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Freeze outranks branch: the whole pipe holds, so no bubble is loaded.
    always_comb begin
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        freeze    = 1'b0;
        if (rst) begin
            bubble_ex = 1'b1;
            flush_id  = 1'b1;
        end else if (frz) begin
            freeze   = 1'b1;
            stall_if = 1'b1;
        end else if (branch_taken_ex) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (lu) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign state_dbg = state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_if),
        .flush_i        (flush_id),
        .stall_cycles_o (stall_cycles_o),
        .flush_cnt_o    (flush_cnt_o)
    );
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench for hazard_stall_unit.
// Directed scenarios then random traffic, checked against a cycle-count model.
module tb_hazard_stall_unit;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       uses_rs1_id, uses_rs2_id;
    logic       mem_read_ex, branch_taken_ex;
    logic       dmem_req_mem, dmem_ack_mem;
    logic       stall_if, bubble_ex, flush_id, freeze, mem_err;
    logic [1:0] state_dbg;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .uses_rs1_id     (uses_rs1_id),
        .uses_rs2_id     (uses_rs2_id),
        .rd_ex           (rd_ex),
        .mem_read_ex     (mem_read_ex),
        .branch_taken_ex (branch_taken_ex),
        .dmem_req_mem    (dmem_req_mem),
        .dmem_ack_mem    (dmem_ack_mem),
        .stall_if        (stall_if),
        .bubble_ex       (bubble_ex),
        .flush_id        (flush_id),
        .freeze          (freeze),
        .mem_err         (mem_err),
        .state_dbg       (state_dbg)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles_o  (stall_cycles_o),
        .flush_cnt_o     (flush_cnt_o)
`endif
    );

    typedef struct packed {
        logic       stall;
        logic       bubble;
        logic       flush;
        logic       freeze;
        logic       err;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    // Model: m_pend = cycles the current access has been outstanding
    // (0 = none); reaching TO+1 means the access is being aborted.
    int               m_pend = 0;
    bit               m_err  = 1'b0;
    logic [CNT_W-1:0] m_scnt = '0;
    logic [CNT_W-1:0] m_fcnt = '0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    task automatic model_step();
        exp_t e;
        bit   lu, frz, abort_now;
        lu = mem_read_ex && (rd_ex != 0) &&
             ((uses_rs1_id && rs1_id == rd_ex) ||
              (uses_rs2_id && rs2_id == rd_ex));
        abort_now = (m_pend == TO + 1);
        e = '0;
        e.err = m_err;
        if (abort_now) begin
            e.st = 2'd2;
            frz  = 1'b0;
        end else if (m_pend > 0) begin
            e.st = 2'd1;
            frz  = !dmem_ack_mem;
        end else begin
            e.st = 2'd0;
            frz  = dmem_req_mem && !dmem_ack_mem;
        end
        if (rst) begin
            e.bubble = 1'b1;
            e.flush  = 1'b1;
        end else if (frz) begin
            e.freeze = 1'b1;
            e.stall  = 1'b1;
        end else if (branch_taken_ex) begin
            e.flush  = 1'b1;
            e.bubble = 1'b1;
        end else if (lu) begin
            e.stall  = 1'b1;
            e.bubble = 1'b1;
        end
        q.push_back(e);
        if (rst) begin
            m_pend = 0;
            m_err  = 1'b0;
            m_scnt = '0;
            m_fcnt = '0;
        end else begin
            m_scnt = m_scnt + CNT_W'(e.stall);
            m_fcnt = m_fcnt + CNT_W'(e.flush);
            if (abort_now) begin
                m_pend = 0;
            end else if (m_pend > 0) begin
                if (dmem_ack_mem) begin
                    m_pend = 0;
                end else begin
                    m_pend++;
                    if (m_pend == TO + 1) m_err = 1'b1;
                end
            end else if (frz) begin
                m_pend = 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit req, input bit ack,
                       input bit mr, input bit br, input bit u1,
                       input bit u2, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d);
        rst             = r;
        dmem_req_mem    = req;
        dmem_ack_mem    = ack;
        mem_read_ex     = mr;
        branch_taken_ex = br;
        uses_rs1_id     = u1;
        uses_rs2_id     = u2;
        rs1_id          = a;
        rs2_id          = b;
        rd_ex           = d;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall_if",  32'(stall_if),  32'(e.stall));
            chk("bubble_ex", 32'(bubble_ex), 32'(e.bubble));
            chk("flush_id",  32'(flush_id),  32'(e.flush));
            chk("freeze",    32'(freeze),    32'(e.freeze));
            chk("mem_err",   32'(mem_err),   32'(e.err));
            chk("state_dbg", 32'(state_dbg), 32'(e.st));
        end
    end

    initial begin
        bit busy;
        int dly;
        rst = 1'b1;
        {dmem_req_mem, dmem_ack_mem, mem_read_ex, branch_taken_ex} = '0;
        {uses_rs1_id, uses_rs2_id} = '0;
        {rs1_id, rs2_id, rd_ex} = '0;
        @(posedge clk);
        #1;
        // Reset state and in-reset squash outputs.
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(1);
        // Load-use on rs2, then the load has moved on.
        cyc(0, 0, 0, 1, 0, 0, 1, 5'd1, 5'd5, 5'd5);
        cyc(0, 0, 0, 0, 0, 0, 1, 5'd1, 5'd5, 5'd7);
        // rd_ex = x0 never stalls.
        cyc(0, 0, 0, 1, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        // Branch together with load-use.
        cyc(0, 0, 0, 1, 1, 1, 0, 5'd9, 5'd2, 5'd9);
        idle(1);
        // Three-cycle memory wait, then a zero-wait access.
        cyc(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 1, 0, 1, 0, 1, 0, 5'd3, 5'd0, 5'd3);
        cyc(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(1);
        // Timeout: request held without ack through WAIT and ABORT.
        for (int i = 0; i < TO + 2; i++) cyc(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(3);
        // Reset in the middle of a wait.
        cyc(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        cyc(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(2);
        // Three load-use stalls and two branches for the counters.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 1, 0, 5'd4, 5'd0, 5'd4);
            idle(1);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
            idle(1);
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles_dir", 32'(stall_cycles_o), 32'(m_scnt));
        chk("flush_cnt_dir",    32'(flush_cnt_o),    32'(m_fcnt));
`endif
        // Random traffic.
        busy = 1'b0;
        dly  = 0;
        for (int n = 0; n < 3000; n++) begin
            bit r;
            r = ($urandom_range(0, 63) == 0);
            if (!busy && ($urandom_range(0, 3) == 0)) begin
                busy = 1'b1;
                dly  = $urandom_range(0, TO + 2);
            end
            cyc(r, busy, busy && (dly == 0),
                $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)));
            if (r || (busy && dly == 0)) busy = 1'b0;
            else if (busy) dly--;
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles_rnd", 32'(stall_cycles_o), 32'(m_scnt));
        chk("flush_cnt_rnd",    32'(flush_cnt_o),    32'(m_fcnt));
`endif
        @(negedge clk);
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
